// File: rtl/sofa_scan_chain_ctrl.sv
// sofa_scan_chain_ctrl: shifts a pattern into a sofa_plus_dff scan chain, optionally captures, shifts the result out
// Ports: C/R clock and sync active-high reset; start/op/load_data/cap_cycles launch an operation from IDLE;
// mode_sel_wr/mode_sel_in write the broadcast mode register in IDLE; scan_do is the last flop's Q;
// scan_en/scan_di/mode_sel drive the chain; busy/done/unload_data report status and the unloaded contents.
// Optional macro SOFA_SCAN_PARITY_EN adds load_par input and par_err output (op=0 loopback parity check).
module sofa_scan_chain_ctrl #(
    parameter int         CHAIN_LEN = 16,
    parameter int         CAP_W     = 4,
    parameter logic [1:0] MODE_RST  = 2'b00
) (
    input  logic                 C,
    input  logic                 R,
    input  logic                 start,
    input  logic                 op,
    input  logic [CHAIN_LEN-1:0] load_data,
    input  logic [CAP_W-1:0]     cap_cycles,
    input  logic                 mode_sel_wr,
    input  logic [1:0]           mode_sel_in,
    input  logic                 scan_do,
`ifdef SOFA_SCAN_PARITY_EN
    input  logic                 load_par,
    output logic                 par_err,
`endif
    output logic                 scan_en,
    output logic                 scan_di,
    output logic [1:0]           mode_sel,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] unload_data
);
    localparam int CW = $clog2(CHAIN_LEN);
    localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE} state_t;

    state_t               state, state_nx;
    logic [CW-1:0]        cnt;
    logic [CAP_W-1:0]     cap;
    logic [CHAIN_LEN-1:0] ld_sr;
    logic [CHAIN_LEN-2:0] ul_sr;
    logic                 op_q;
    logic                 shifting;
    logic                 last;

    assign shifting = state == SHIFT_IN || state == SHIFT_OUT;
    assign last     = cnt == LAST;
    // ld_sr drains to zero during SHIFT_IN, so scan_di is 0 in every other state
    assign scan_di  = ld_sr[CHAIN_LEN-1];

    always_ff @(posedge C)
        state <= R ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = start ? SHIFT_IN : IDLE;
            SHIFT_IN:  if (last) state_nx = op_q ? CAPTURE : DONE;
            // cap holds the remaining capture cycles; 0 is treated as 1
            CAPTURE:   if (cap <= CAP_W'(1)) state_nx = SHIFT_OUT;
            SHIFT_OUT: if (last) state_nx = DONE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge C) begin
        if (R) begin
            scan_en     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mode_sel    <= MODE_RST;
            unload_data <= '0;
            ld_sr       <= '0;
            ul_sr       <= '0;
            cnt         <= '0;
            cap         <= '0;
            op_q        <= 1'b0;
        end else begin
            scan_en <= state_nx == SHIFT_IN || state_nx == SHIFT_OUT;
            busy    <= state_nx != IDLE;
            done    <= state_nx == DONE;
            if (state == IDLE && mode_sel_wr) mode_sel <= mode_sel_in;
            if (state == IDLE && start) begin
                ld_sr <= load_data;
                op_q  <= op;
                cap   <= cap_cycles;
            end
            if (state == SHIFT_IN) ld_sr <= ld_sr << 1;
            if (state == CAPTURE) cap <= cap - 1'b1;
            if (shifting) begin
                ul_sr <= (CHAIN_LEN-1)'({ul_sr, scan_do});
                cnt   <= last ? '0 : cnt + 1'b1;
            end
            // the final sample is taken on the same edge that enters DONE
            if (state_nx == DONE) unload_data <= {ul_sr, scan_do};
        end
    end

`ifdef SOFA_SCAN_PARITY_EN
    logic lp_q, rec_par, rec_vld, acc;

    // compares the parity of what an op=0 unloads against the parity recorded by the previous op=0 load
    always_ff @(posedge C) begin
        if (R) begin
            {par_err, lp_q, rec_par, rec_vld, acc} <= '0;
        end else if (state == IDLE && start) begin
            par_err <= 1'b0;
            lp_q    <= load_par;
            acc     <= 1'b0;
        end else if (state == SHIFT_IN) begin
            acc <= acc ^ scan_do;
            if (state_nx == DONE) begin
                par_err <= rec_vld && ((acc ^ scan_do) != rec_par);
                rec_par <= lp_q;
                rec_vld <= 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_sofa_scan_chain_ctrl.sv
// tb_sofa_scan_chain_ctrl: directed table-driven bench with a behavioural 16-flop scan chain model
module tb_sofa_scan_chain_ctrl;
    logic        C = 1'b0;
    logic        R = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [15:0] load_data = '0;
    logic [3:0]  cap_cycles = '0;
    logic        mode_sel_wr = 1'b0;
    logic [1:0]  mode_sel_in = '0;
    logic        scan_do;
    logic        scan_en, scan_di, busy, done;
    logic [1:0]  mode_sel;
    logic [15:0] unload_data;

    logic [15:0] chain = '0;
    logic        pre = 1'b0;
    logic [15:0] pre_val = '0;
    logic        inv = 1'b0;

    int passed = 0;
    int total = 0;

    sofa_scan_chain_ctrl #(.CHAIN_LEN(16), .CAP_W(4), .MODE_RST(2'b00)) dut (
        .C(C), .R(R), .start(start), .op(op), .load_data(load_data), .cap_cycles(cap_cycles),
        .mode_sel_wr(mode_sel_wr), .mode_sel_in(mode_sel_in), .scan_do(scan_do),
        .scan_en(scan_en), .scan_di(scan_di), .mode_sel(mode_sel), .busy(busy), .done(done),
        .unload_data(unload_data)
    );

    always #5 C = ~C;

    // chain[0] is the first flop, chain[15] the last; functional D is either hold or ~Q
    assign scan_do = chain[15];
    always @(posedge C) begin
        if (pre) chain <= pre_val;
        else if (scan_en) chain <= {chain[14:0], scan_di};
        else if (inv) chain <= ~chain;
    end

    typedef struct {
        logic        o;
        logic [15:0] ld;
        logic [3:0]  cp;
        logic        pr;
        logic [15:0] pv;
        logic        iv;
        logic [15:0] eul;
        int          elat;
        int          een;
        int          ecap;
    } vec_t;

    vec_t tv[6];

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic preload(input logic [15:0] v);
        pre = 1'b1;
        pre_val = v;
        tick();
        pre = 1'b0;
    endtask

    task automatic run(input logic o, input logic [15:0] ld, input logic [3:0] cp, input int poke,
                       output int lat, output int en, output int capc, output logic [1:0] ms1);
        op = o;
        load_data = ld;
        cap_cycles = cp;
        start = 1'b1;
        tick();
        start = 1'b0;
        mode_sel_wr = 1'b0;
        op = ~o;
        load_data = ~ld;
        cap_cycles = ~cp;
        ms1 = mode_sel;
        lat = 0;
        en = 0;
        capc = 0;
        for (int n = 1; n <= 300; n++) begin
            if (scan_en) en++;
            if (busy && !scan_en && !done) capc++;
            if (done) begin
                lat = n;
                break;
            end
            if (n == poke) begin
                start = 1'b1;
                op = 1'b0;
                mode_sel_wr = 1'b1;
                mode_sel_in = 2'b11;
            end
            tick();
            start = 1'b0;
            mode_sel_wr = 1'b0;
        end
    endtask

    initial begin
        int lat, en, capc, dn;
        logic [1:0] ms1;
        tv[0] = '{1'b0, 16'hA5C3, 4'd0,  1'b1, 16'h1234, 1'b0, 16'h1234, 17, 16, 0};
        tv[1] = '{1'b0, 16'hBEEF, 4'd0,  1'b0, 16'h0000, 1'b0, 16'hA5C3, 17, 16, 0};
        tv[2] = '{1'b0, 16'h0000, 4'd0,  1'b0, 16'h0000, 1'b0, 16'hBEEF, 17, 16, 0};
        tv[3] = '{1'b1, 16'h00FF, 4'd3,  1'b0, 16'h0000, 1'b1, 16'hFF00, 36, 32, 3};
        tv[4] = '{1'b1, 16'h1234, 4'd0,  1'b0, 16'h0000, 1'b1, 16'hEDCB, 34, 32, 1};
        tv[5] = '{1'b1, 16'h5A5A, 4'd15, 1'b0, 16'h0000, 1'b0, 16'h5A5A, 48, 32, 15};

        tick();
        tick();
        chk("rst_scan_en", 32'(scan_en), 32'd0);
        chk("rst_scan_di", 32'(scan_di), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_unload", 32'(unload_data), 32'd0);
        chk("rst_mode", 32'(mode_sel), 32'd0);
        R = 1'b0;
        tick();

        mode_sel_in = 2'b01;
        mode_sel_wr = 1'b1;
        tick();
        mode_sel_wr = 1'b0;
        chk("mode_idle_wr01", 32'(mode_sel), 32'd1);

        for (int i = 0; i < 6; i++) begin
            inv = tv[i].iv;
            if (tv[i].pr) preload(tv[i].pv);
            run(tv[i].o, tv[i].ld, tv[i].cp, 0, lat, en, capc, ms1);
            chk($sformatf("v%0d_unload", i), 32'(unload_data), 32'(tv[i].eul));
            chk($sformatf("v%0d_latency", i), lat, tv[i].elat);
            chk($sformatf("v%0d_scan_en_cycles", i), en, tv[i].een);
            chk($sformatf("v%0d_capture_cycles", i), capc, tv[i].ecap);
            tick();
        end
        inv = 1'b0;

        preload(16'h3C3C);
        run(1'b0, 16'h0F0F, 4'd0, 4, lat, en, capc, ms1);
        chk("busy_start_latency", lat, 17);
        chk("busy_start_unload", 32'(unload_data), 32'h3C3C);
        chk("busy_mode_dropped", 32'(mode_sel), 32'd1);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) dn++;
        end
        chk("no_second_done", dn, 0);
        chk("idle_after_run", 32'(busy), 32'd0);

        mode_sel_in = 2'b11;
        mode_sel_wr = 1'b1;
        tick();
        mode_sel_wr = 1'b0;
        chk("mode_idle_wr11", 32'(mode_sel), 32'd3);

        preload(16'h8001);
        mode_sel_in = 2'b10;
        mode_sel_wr = 1'b1;
        run(1'b0, 16'hC001, 4'd0, 0, lat, en, capc, ms1);
        chk("mode_with_start", 32'(ms1), 32'd2);
        chk("mode_with_start_unload", 32'(unload_data), 32'h8001);
        tick();

        op = 1'b0;
        load_data = 16'hFFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_shift_scan_en", 32'(scan_en), 32'd1);
        R = 1'b1;
        tick();
        R = 1'b0;
        chk("midrst_scan_en", 32'(scan_en), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_mode", 32'(mode_sel), 32'd0);
        chk("midrst_unload", 32'(unload_data), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        preload(16'h4321);
        run(1'b0, 16'h1111, 4'd0, 0, lat, en, capc, ms1);
        chk("post_rst_latency", lat, 17);
        chk("post_rst_unload", 32'(unload_data), 32'h4321);
        chk("post_rst_scan_en_cycles", en, 16);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
